// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-stage branch resolver.
// Covers FSM state encoding and one-hot branch-type decode with priority.
package branch_resolve_unit_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } brs_state_t;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_B    = 3'b001;
  localparam logic [2:0] BR_CBZ  = 3'b010;
  localparam logic [2:0] BR_CBNZ = 3'b100;

  // Illegal multi-hot encodings collapse to one type: B beats CBZ beats CBNZ.
  function automatic logic [2:0] decode_branch(input logic is_b,
                                               input logic is_cbz,
                                               input logic is_cbnz);
    logic [2:0] br_type;
    br_type = BR_NONE;
    if (is_b)
      br_type = BR_B;
    else if (is_cbz)
      br_type = BR_CBZ;
    else if (is_cbnz)
      br_type = BR_CBNZ;
    return br_type;
  endfunction

endpackage

// File: rtl/zero_detect_64.sv
// Combinational all-zero detect on the forwarded Rt operand.
module zero_detect_64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] operand,
  output logic         zero
);

  assign zero = (operand == '0);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves CBZ/CBNZ/B in execute, issues a registered one-cycle redirect,
// holds a flush window afterwards, and keeps a saturating taken-branch count.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              is_cbz,
  input  logic              is_cbnz,
  input  logic              is_b,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm_offset,
  input  logic [ADDR_W-1:0] rt_val,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  brs_state_t        state_reg, state_next;
  logic [FCW-1:0]    flush_cnt_reg, flush_cnt_next;
  logic              redirect_valid_reg, redirect_valid_next;
  logic [ADDR_W-1:0] redirect_pc_reg, redirect_pc_next;
  logic [CNT_W-1:0]  taken_count_reg, taken_count_next;

  logic              zero;
  logic [2:0]        br_type;
  logic              taken;
  logic [ADDR_W-1:0] target;

  zero_detect_64 #(.W(ADDR_W)) u_zero_detect (
    .operand (rt_val),
    .zero    (zero)
  );

  assign br_type = decode_branch(is_b, is_cbz, is_cbnz);

  always_comb begin
    taken = 1'b0;
    if (in_valid) begin
      case (br_type)
        BR_B:    taken = 1'b1;
        BR_CBZ:  taken = zero;
        BR_CBNZ: taken = ~zero;
        default: taken = 1'b0;
      endcase
    end
  end

  // Word offset scaled to bytes; overflow wraps silently.
  assign target = pc + {imm_offset[ADDR_W-3:0], 2'b00};

  always_comb begin
    state_next          = state_reg;
    flush_cnt_next      = flush_cnt_reg;
    redirect_valid_next = redirect_valid_reg;
    redirect_pc_next    = redirect_pc_reg;
    taken_count_next    = taken_count_reg;
    // A stalled pipeline freezes everything, including a pending redirect pulse.
    if (!stall) begin
      redirect_valid_next = 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (taken) begin
            redirect_valid_next = 1'b1;
            redirect_pc_next    = target;
            flush_cnt_next      = FCW'(FLUSH_CYCLES - 1);
            state_next          = ST_FLUSH;
            if (taken_count_reg != '1)
              taken_count_next = taken_count_reg + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == '0)
            state_next = ST_IDLE;
          else
            flush_cnt_next = flush_cnt_reg - FCW'(1);
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      flush_cnt_reg      <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      taken_count_reg    <= '0;
    end else begin
      state_reg          <= state_next;
      flush_cnt_reg      <= flush_cnt_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
      taken_count_reg    <= taken_count_next;
    end
  end

  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign flush          = (state_reg == ST_FLUSH);
  assign busy           = (state_reg == ST_FLUSH);
  assign taken_count    = taken_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a default build and a CNT_W=4 build
// share stimulus; a cycle model queues expected outputs that are checked after each edge.
module tb_branch_resolve_unit;

  localparam int AW = 64;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          reset, in_valid, stall, is_cbz, is_cbnz, is_b;
  logic [AW-1:0] pc, imm_offset, rt_val;

  logic          redirect_valid, flush, busy;
  logic [AW-1:0] redirect_pc;
  logic [15:0]   taken_count;

  logic          redirect_valid4, flush4, busy4;
  logic [AW-1:0] redirect_pc4;
  logic [3:0]    taken_count4;

  int check_count = 0;
  int pass_count  = 0;
  int txn         = 0;

  typedef struct {
    logic          rv;
    logic [AW-1:0] rpc;
    logic          fl;
    logic [15:0]   cnt;
    logic [3:0]    cnt4;
  } exp_t;

  exp_t exp_q[$];

  logic          m_rv   = 1'b0;
  logic [AW-1:0] m_pc   = '0;
  int            m_left = 0;
  int            m_cnt  = 0;
  int            m_cnt4 = 0;

  branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .is_cbz(is_cbz), .is_cbnz(is_cbnz), .is_b(is_b),
    .pc(pc), .imm_offset(imm_offset), .rt_val(rt_val),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .busy(busy), .taken_count(taken_count)
  );

  branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .is_cbz(is_cbz), .is_cbnz(is_cbnz), .is_b(is_b),
    .pc(pc), .imm_offset(imm_offset), .rt_val(rt_val),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .flush(flush4), .busy(busy4), .taken_count(taken_count4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp)
      pass_count++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input logic rst, input logic st, input logic v,
                      input logic b, input logic cbz, input logic cbnz,
                      input logic [AW-1:0] p, input logic [AW-1:0] imm,
                      input logic [AW-1:0] rt);
    logic tk;
    exp_t e, o;
    @(negedge clk);
    reset = rst; stall = st; in_valid = v;
    is_b = b; is_cbz = cbz; is_cbnz = cbnz;
    pc = p; imm_offset = imm; rt_val = rt;

    tk = 1'b0;
    if (v) begin
      if (b)         tk = 1'b1;
      else if (cbz)  tk = (rt == 0);
      else if (cbnz) tk = (rt != 0);
    end
    if (rst) begin
      m_rv = 1'b0; m_pc = '0; m_left = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (!st) begin
      if (m_left > 0) begin
        m_left--;
        m_rv = 1'b0;
      end else if (tk) begin
        m_rv   = 1'b1;
        m_pc   = p + imm * 4;
        m_left = FC;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15)   m_cnt4++;
      end else begin
        m_rv = 1'b0;
      end
    end
    e.rv = m_rv; e.rpc = m_pc; e.fl = (m_left > 0);
    e.cnt = 16'(m_cnt); e.cnt4 = 4'(m_cnt4);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    txn++;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 64'd0, 64'd1);
    end else begin
      o = exp_q.pop_front();
      check_eq("redirect_valid", 64'(redirect_valid), 64'(o.rv));
      check_eq("redirect_pc",    redirect_pc,         o.rpc);
      check_eq("flush",          64'(flush),          64'(o.fl));
      check_eq("busy",           64'(busy),           64'(o.fl));
      check_eq("taken_count",    64'(taken_count),    64'(o.cnt));
      check_eq("taken_count4",   64'(taken_count4),   64'(o.cnt4));
      check_eq("redirect_pc4",   redirect_pc4,        o.rpc);
      check_eq("flush4",         64'(flush4),         64'(o.fl));
    end
    $display("txn %0d rst=%0b stall=%0b v=%0b rv=%0b rpc=%h flush=%0b busy=%0b cnt=%0d cnt4=%0d",
             txn, rst, st, v, redirect_valid, redirect_pc, flush, busy, taken_count, taken_count4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
  endtask

  initial begin
    logic [AW-1:0] rp, ri, rr;
    int kind;
    logic r_rst, r_st, r_v, r_b, r_z, r_nz;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    check_eq("reset_rv", 64'(redirect_valid), 64'd0);
    check_eq("reset_cnt", 64'(taken_count), 64'd0);

    // 1: taken CBZ
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1000, 64'd4, 64'd0);
    check_eq("t1_rv", 64'(redirect_valid), 64'd1);
    check_eq("t1_pc", redirect_pc, 64'h1010);
    check_eq("t1_cnt", 64'(taken_count), 64'd1);
    idle(1);
    check_eq("t1_flush2", 64'(flush), 64'd1);
    check_eq("t1_rv_pulse", 64'(redirect_valid), 64'd0);
    idle(1);
    check_eq("t1_flush_end", 64'(flush), 64'd0);
    check_eq("t1_pc_hold", redirect_pc, 64'h1010);

    // 2: not-taken CBZ, then CBNZ with same operands, then illegal CBZ+CBNZ
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h2000, 64'd3, 64'd5);
    check_eq("t2_nt_rv", 64'(redirect_valid), 64'd0);
    check_eq("t2_nt_flush", 64'(flush), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h2000, 64'd3, 64'd5);
    check_eq("t2_cbnz_pc", redirect_pc, 64'h200C);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3000, 64'd1, 64'd5);
    check_eq("t2_prio_rv", 64'(redirect_valid), 64'd0);

    // 3: wrap-around target and back-to-back B during flush
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
    check_eq("t3_wrap_pc", redirect_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h4000, 64'd8, 64'd7);
    check_eq("t3_b2b_rv", 64'(redirect_valid), 64'd0);
    check_eq("t3_b2b_pc", redirect_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    idle(2);

    // 4: taken CBZ then 3 stall cycles
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h5000, 64'd2, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
      check_eq("t4_stall_rv", 64'(redirect_valid), 64'd1);
    end
    idle(1);
    check_eq("t4_release_rv", 64'(redirect_valid), 64'd0);
    check_eq("t4_release_flush", 64'(flush), 64'd1);
    idle(2);

    // 5: reset during flush with a taken branch in the same cycle
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h6000, 64'd1, 64'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h7000, 64'd1, 64'd0);
    check_eq("t5_rv", 64'(redirect_valid), 64'd0);
    check_eq("t5_flush", 64'(flush), 64'd0);
    check_eq("t5_busy", 64'(busy), 64'd0);
    check_eq("t5_pc", redirect_pc, 64'd0);
    check_eq("t5_cnt", 64'(taken_count), 64'd0);

    // 6: saturation of the 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'(i * 64), 64'd1, 64'd0);
      if (i >= 15) check_eq("t6_sat4", 64'(taken_count4), 64'd15);
      idle(2);
    end
    check_eq("t6_cnt16", 64'(taken_count), 64'd17);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      kind  = int'($urandom_range(0, 4));
      r_b   = (kind == 1) || (kind == 4);
      r_z   = (kind == 2) || (kind == 4);
      r_nz  = (kind == 3);
      r_v   = ($urandom_range(0, 3) != 0);
      r_st  = ($urandom_range(0, 5) == 0);
      r_rst = ($urandom_range(0, 60) == 0);
      rp    = {$urandom, $urandom};
      ri    = {$urandom, $urandom};
      rr    = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom, $urandom};
      step(r_rst, r_st, r_v, r_b, r_z, r_nz, rp, ri, rr);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
